bcd_counter_n: RTL and testbench
================================

# bcd_counter_n

Parametrised multi-digit BCD counter. Successor to the fixed two-digit tens/ones counter.
- Adds configurable digit count, up/down direction, count enable and synchronous load.
- Adds a runtime-programmable modulus limit, a wrap or saturate mode, and terminal-count and zero flags.
- Drives decimal displays and timebases in the lab designs from a single clock domain.

## Interface
- DIGITS, default 2: number of BCD digits; legal range 1..8.
- SATURATE, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-low reset.
- en  in  1: count enable; one step per rising clk edge while high.
- up  in  1: direction; 1 = increment, 0 = decrement. Sampled only when en=1.
- load  in  1: synchronous load; takes priority over en.
- load_val  in  4*DIGITS: BCD value to load; digit i sits at bits [4i+3:4i], digit 0 is the least significant.
- limit  in  4*DIGITS: BCD upper bound, inclusive. The count range is 0..limit.
- count  out  4*DIGITS: registered BCD count.
- tc  out  1: registered terminal-count pulse.
- zero  out  1: combinational, count == 0.

## Operation
- Digit sanitising:
  - Any digit of load_val or limit with a value above 9 is read as 9.
  - Sanitising happens before any compare or load.
- Priority on each rising clk edge: reset (asynchronous) > load > en > hold.
- Load:
  - count ← min(sanitised load_val, sanitised limit).
  - tc ← 0.
- Up step (en=1, up=1):
  - count < limit: BCD increment. A digit at 9 becomes 0 and carries into the next digit, e.g. 0x0199 → 0x0200.
  - count ≥ limit, SATURATE=0: count ← 0, tc ← 1.
  - count ≥ limit, SATURATE=1: count ← limit, tc ← 1.
- Down step (en=1, up=0):
  - count > limit (limit lowered at runtime): count ← limit, tc ← 0.
  - 0 < count ≤ limit: BCD decrement. A digit at 0 becomes 9 and borrows from the next digit, e.g. 0x0200 → 0x0199.
  - count == 0, SATURATE=0: count ← limit, tc ← 1.
  - count == 0, SATURATE=1: count held at 0, tc ← 1.
- limit == 0:
  - count stays 0.
  - Every enabled step asserts tc.
- No enabled step and no load: count held, tc ← 0.
- Compares between count and limit are unsigned BCD compares, which equal numeric compares on valid BCD.
- All count digits are always valid BCD (0..9). No non-BCD state is reachable.

## Timing
- Reset asserted (reset=0): count = 0, tc = 0, zero = 1, immediately and independent of clk.
- Reset deassertion:
  - Takes effect asynchronously.
  - The first count update happens on the first rising edge after reset=1.
- count and tc update on the same rising edge. tc is high for exactly one cycle per bound event, and stays high on consecutive enabled bound events.
- Latency from input to output:
  - en, load or up sampled at edge N → new count visible after edge N.
  - zero follows count combinationally in that cycle.
- Changes to limit apply at the next edge.
- Reset mid-count clears everything. The count restarts from 0 with no tc pulse.
- Simultaneous load and en: load wins and en is ignored for that cycle.

## Test plan
- DIGITS=2, limit=0x99, up, en held for 100 cycles after reset:
  - count steps 00, 01, …, 09, 10, …, 99, then 00.
  - tc is high only in the cycle after the 99→00 edge.
  - zero is high at 00.
- DIGITS=2, limit=0x59, down from 0x00:
  - First step gives count 0x59 with tc=1.
  - Next step gives 0x58 with tc=0.
- Load checks, limit=0x50:
  - load_val=0x3A loads 0x39.
  - load_val=0x75 loads 0x50.
  - load and en together: load value taken, no step.
- SATURATE=1, limit=0x20:
  - Up from 0x19 gives 0x20, then 0x20 with tc=1 on every further enabled cycle.
  - Down from 0x00 holds 0x00 with tc=1.
- DIGITS=3:
  - 0x199 up gives 0x200.
  - 0x200 down gives 0x199.
  - With count at 0x150, lowering limit to 0x100 then stepping down gives 0x100 with tc=0.
- Assert reset=0 asynchronously mid-cycle at count 0x47:
  - count is 0x00, tc 0 and zero 1 before the next clk edge.
  - After release, counting resumes from 0x00.

Source files
------------

// File: rtl/bcd_counter_n.sv
// Parametrised multi-digit BCD counter with up/down, synchronous load, programmable limit,
// wrap or saturate at the bounds, registered terminal-count pulse and combinational zero flag.
module bcd_counter_n #(
    parameter int unsigned DIGITS   = 2,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  zero
);

    localparam int unsigned W = 4 * DIGITS;

    // Digits above 9 are clamped to 9 so every compare and load sees valid BCD.
    function automatic logic [W-1:0] sanitise(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    logic [W-1:0] r_count;
    logic         r_tc;
    logic [W-1:0] w_count_nxt;
    logic         w_tc_nxt;
    logic [W-1:0] w_lim;
    logic [W-1:0] w_ldv;

    assign w_lim = sanitise(limit);
    assign w_ldv = sanitise(load_val);

    // Plain unsigned compares are numeric compares because both sides are valid BCD.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        if (load) begin
            w_count_nxt = (w_ldv < w_lim) ? w_ldv : w_lim;
        end else if (en) begin
            if (up) begin
                if (r_count < w_lim) begin
                    w_count_nxt = bcd_inc(r_count);
                end else begin
                    w_count_nxt = SATURATE ? w_lim : '0;
                    w_tc_nxt    = 1'b1;
                end
            end else begin
                if (r_count > w_lim) begin
                    w_count_nxt = w_lim;
                end else if (r_count != '0) begin
                    w_count_nxt = bcd_dec(r_count);
                end else begin
                    w_count_nxt = SATURATE ? '0 : w_lim;
                    w_tc_nxt    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign zero  = (r_count == '0);

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n: three instances (2-digit wrap, 2-digit saturate,
// 3-digit wrap) checked against an integer-arithmetic reference model.
module tb_bcd_counter_n;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [7:0]  lv_a, lim_a, cnt_a;
    logic [7:0]  lv_b, lim_b, cnt_b;
    logic [11:0] lv_c, lim_c, cnt_c;
    logic        tc_a, tc_b, tc_c;
    logic        zero_a, zero_b, zero_c;

    int n_cmp;
    int n_bad;

    int m_cnt [3];
    bit m_tc  [3];
    int digs  [3] = '{2, 2, 3};
    bit sats  [3] = '{1'b0, 1'b1, 1'b0};

    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0)) u_a (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv_a), .limit(lim_a), .count(cnt_a), .tc(tc_a), .zero(zero_a)
    );

    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b1)) u_b (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv_b), .limit(lim_b), .count(cnt_b), .tc(tc_b), .zero(zero_b)
    );

    bcd_counter_n #(.DIGITS(3), .SATURATE(1'b0)) u_c (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(lv_c), .limit(lim_c), .count(cnt_c), .tc(tc_c), .zero(zero_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2int(input logic [31:0] v, input int nd);
        int r, p, d;
        r = 0;
        p = 1;
        for (int k = 0; k < nd; k++) begin
            d = int'(v[4*k +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input int x, input int nd);
        logic [31:0] r;
        int          y;
        r = '0;
        y = x;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] get_lv(input int i);
        case (i)
            0:       return 32'(lv_a);
            1:       return 32'(lv_b);
            default: return 32'(lv_c);
        endcase
    endfunction

    function automatic logic [31:0] get_lim(input int i);
        case (i)
            0:       return 32'(lim_a);
            1:       return 32'(lim_b);
            default: return 32'(lim_c);
        endcase
    endfunction

    function automatic logic [31:0] get_cnt(input int i);
        case (i)
            0:       return 32'(cnt_a);
            1:       return 32'(cnt_b);
            default: return 32'(cnt_c);
        endcase
    endfunction

    function automatic logic [31:0] get_tc(input int i);
        case (i)
            0:       return 32'(tc_a);
            1:       return 32'(tc_b);
            default: return 32'(tc_c);
        endcase
    endfunction

    function automatic logic [31:0] get_zero(input int i);
        case (i)
            0:       return 32'(zero_a);
            1:       return 32'(zero_b);
            default: return 32'(zero_c);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: numeric value of the count, updated from the rules on each edge.
    task automatic model_update();
        int lv, lim, c;
        for (int i = 0; i < 3; i++) begin
            lv  = bcd2int(get_lv(i), digs[i]);
            lim = bcd2int(get_lim(i), digs[i]);
            c   = m_cnt[i];
            m_tc[i] = 1'b0;
            if (load) begin
                c = (lv < lim) ? lv : lim;
            end else if (en) begin
                if (up) begin
                    if (c < lim) c = c + 1;
                    else begin
                        c = sats[i] ? lim : 0;
                        m_tc[i] = 1'b1;
                    end
                end else begin
                    if (c > lim) c = lim;
                    else if (c > 0) c = c - 1;
                    else begin
                        c = sats[i] ? 0 : lim;
                        m_tc[i] = 1'b1;
                    end
                end
            end
            m_cnt[i] = c;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_tc[i]  = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count%0d", i), get_cnt(i), int2bcd(m_cnt[i], digs[i]));
            chk($sformatf("tc%0d", i), get_tc(i), 32'(m_tc[i]));
            chk($sformatf("zero%0d", i), get_zero(i), 32'(m_cnt[i] == 0));
        end
    endtask

    task automatic step(input bit l, input bit e, input bit u);
        load = l;
        en   = e;
        up   = u;
        @(posedge clk);
        #1;
        model_update();
        check_all();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        en    = 1'b0;
        up    = 1'b1;
        load  = 1'b0;
        lv_a  = 8'h00;  lim_a = 8'h99;
        lv_b  = 8'h00;  lim_b = 8'h20;
        lv_c  = 12'h000; lim_c = 12'h999;
        model_reset();
        #1;
        check_all();
        chk("rst_zero", 32'(zero_a), 32'd1);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Full up cycle on the 2-digit wrap instance: 00..99 then 00 with tc.
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, 1'b1, 1'b1);
        end
        chk("up_wrap_cnt", 32'(cnt_a), 32'h00);
        chk("up_wrap_tc", 32'(tc_a), 32'd1);

        // Down from 00 with limit 59.
        lv_a = 8'h00; lv_b = 8'h00; lv_c = 12'h000;
        step(1'b1, 1'b0, 1'b0);
        lim_a = 8'h59;
        step(1'b0, 1'b1, 1'b0);
        chk("down_wrap_cnt", 32'(cnt_a), 32'h59);
        chk("down_wrap_tc", 32'(tc_a), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("down_next_cnt", 32'(cnt_a), 32'h58);
        chk("down_next_tc", 32'(tc_a), 32'd0);

        // Loads with sanitising and limit clamp.
        lim_a = 8'h50;
        lv_a  = 8'h3A;
        step(1'b1, 1'b0, 1'b0);
        chk("load_sanit", 32'(cnt_a), 32'h39);
        lv_a = 8'h75;
        step(1'b1, 1'b0, 1'b0);
        chk("load_clamp", 32'(cnt_a), 32'h50);
        lv_a = 8'h12;
        step(1'b1, 1'b1, 1'b1);
        chk("load_over_en", 32'(cnt_a), 32'h12);

        // Saturating instance at limit 20.
        lv_b = 8'h19;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("sat_reach", 32'(cnt_b), 32'h20);
        chk("sat_reach_tc", 32'(tc_b), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("sat_hold", 32'(cnt_b), 32'h20);
            chk("sat_hold_tc", 32'(tc_b), 32'd1);
        end
        lv_b = 8'h00;
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("sat_floor", 32'(cnt_b), 32'h00);
            chk("sat_floor_tc", 32'(tc_b), 32'd1);
        end

        // 3-digit carry, borrow and lowered limit.
        lim_c = 12'h999;
        lv_c  = 12'h199;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        chk("d3_carry", 32'(cnt_c), 32'h200);
        step(1'b0, 1'b1, 1'b0);
        chk("d3_borrow", 32'(cnt_c), 32'h199);
        lv_c = 12'h150;
        step(1'b1, 1'b0, 1'b0);
        lim_c = 12'h100;
        step(1'b0, 1'b1, 1'b0);
        chk("d3_lowered", 32'(cnt_c), 32'h100);
        chk("d3_lowered_tc", 32'(tc_c), 32'd0);

        // Asynchronous reset mid-cycle at 47.
        lim_a = 8'h99;
        lv_a  = 8'h47;
        step(1'b1, 1'b0, 1'b0);
        chk("pre_rst", 32'(cnt_a), 32'h47);
        load = 1'b0;
        en   = 1'b1;
        up   = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("async_cnt", 32'(cnt_a), 32'h00);
        chk("async_tc", 32'(tc_a), 32'd0);
        chk("async_zero", 32'(zero_a), 32'd1);
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        reset = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        chk("resume", 32'(cnt_a), 32'h01);

        // Randomised traffic, including non-BCD digits and zero limits.
        for (int k = 0; k < 400; k++) begin
            lv_a = 8'($urandom);
            lv_b = 8'($urandom);
            lv_c = 12'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                lim_a = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                lim_b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                lim_c = ($urandom_range(0, 4) == 0) ? 12'h000 : 12'($urandom);
            end
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
